multi_stepper_driver: RTL and testbench

//  N-channel stepper-motor driver; each channel runs a programmable move of K steps.
//  Per-channel controls: direction, step count, start/done handshake, abort.

---
 rtl/stepper_drv_pkg.sv | 44 ++++
 rtl/multi_stepper_driver_if.sv | 35 +++
 rtl/stepper_channel.sv | 123 ++++++++++++
 rtl/multi_stepper_driver.sv | 43 ++++
 tb/tb_multi_stepper_driver.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_drv_pkg.sv
// -----------------------------------------------------------------------------
// stepper_drv_pkg
// Shared types and constants for the multi-channel stepper driver:
//   - per-channel FSM state encoding (IDLE / RUN / DONE)
//   - full-step (wave) and half-step coil pattern tables
//   - phase index width, selected by the HALF_STEP_EN build macro
//   - phase_pattern(): phase index -> 4-bit coil pattern for this build
// Configuration macro: HALF_STEP_EN (defined = 8-entry half-step table,
// undefined = 4-entry full-step table).
// -----------------------------------------------------------------------------
package stepper_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Entry [i] is the coil pattern for phase index i.
    localparam logic [3:0][3:0] FULL_TABLE = {
        4'b1000, 4'b0100, 4'b0010, 4'b0001
    };
    localparam logic [7:0][3:0] HALF_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

`ifdef HALF_STEP_EN
    localparam int PHASE_W = 3;
`else
    localparam int PHASE_W = 2;
`endif

    // The phase register is exactly as wide as the table index, so phase
    // arithmetic wraps naturally (reverse from 0 lands on the last entry).
    function automatic logic [3:0] phase_pattern(input logic [PHASE_W-1:0] idx);
`ifdef HALF_STEP_EN
        return HALF_TABLE[idx];
`else
        return FULL_TABLE[idx];
`endif
    endfunction

endpackage

// File: rtl/multi_stepper_driver_if.sv
// -----------------------------------------------------------------------------
// multi_stepper_driver_if
// Control/status bundle between a motion controller (master) and the
// multi-channel stepper driver (slave).
//   start_i  [N_CH]        per-channel start request
//   dir_i    [N_CH]        1 = forward, 0 = reverse (latched on start)
//   steps_i  [N_CH*CNT_W]  step count, ch c = [c*CNT_W +: CNT_W]
//   abort_i  [N_CH]        stop the running move immediately
//   busy_o   [N_CH]        channel is moving
//   done_o   [N_CH]        one-cycle end-of-move pulse
//   signal_o [N_CH*4]      coil drive, ch c = [c*4 +: 4]
// Configuration macro: none used here (HALF_STEP_EN affects the driver only).
// -----------------------------------------------------------------------------
interface multi_stepper_driver_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       start_i;
    logic [N_CH-1:0]       dir_i;
    logic [N_CH*CNT_W-1:0] steps_i;
    logic [N_CH-1:0]       abort_i;
    logic [N_CH-1:0]       busy_o;
    logic [N_CH-1:0]       done_o;
    logic [N_CH*4-1:0]     signal_o;

    modport master (
        output start_i, dir_i, steps_i, abort_i,
        input  busy_o, done_o, signal_o
    );

    modport slave (
        input  start_i, dir_i, steps_i, abort_i,
        output busy_o, done_o, signal_o
    );
endinterface

// File: rtl/stepper_channel.sv
// -----------------------------------------------------------------------------
// stepper_channel
// One independent stepper channel: IDLE/RUN/DONE FSM, step-rate divider,
// remaining-step counter and persistent phase (motor position) register.
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     start request, honoured only in IDLE
//   dir_i       direction, latched on start (1 = phase+1)
//   steps_i     number of steps, latched on start (0 = immediate done)
//   abort_i     end the move now (a coincident step is still taken)
//   busy_o      high while in RUN
//   done_o      high for the single DONE cycle
//   signal_o    registered coil pattern
// Configuration macro: HALF_STEP_EN selects the half-step table via the package.
// -----------------------------------------------------------------------------
module stepper_channel
    import stepper_drv_pkg::*;
#(
    parameter int STEP_DIV     = 100000,
    parameter int CNT_W        = 16,
    parameter int IDLE_RELEASE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       signal_o
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         sig_q, sig_d;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            phase_q <= '0;
            sig_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            sig_q   <= sig_d;
        end
    end

    // Next-state and datapath logic.
    // NOTE: every signal gets a hold default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (steps_i != '0) begin
                        state_d = ST_RUN;
                        dir_d   = dir_i;
                        rem_d   = steps_i;
                        div_d   = DIV_RELOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (div_q == '0) begin
                    // Step first, so an abort landing on a step edge keeps it.
                    div_d   = DIV_RELOAD;
                    rem_d   = rem_q - 1'b1;
                    phase_d = dir_q ? phase_q + 1'b1 : phase_q - 1'b1;
                    // rem_q is never 0 in RUN, so it cannot underflow.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
                if (abort_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. The coil register follows the post-edge phase but is gated by
    // the pre-edge state: the final step pattern stays driven through the
    // DONE cycle, and a zero-step request never energises the coils.
    always_comb begin
        busy_o = (state_q == ST_RUN);
        done_o = (state_q == ST_DONE);
        if (state_q == ST_RUN || IDLE_RELEASE == 0) begin
            sig_d = phase_pattern(phase_d);
        end else begin
            sig_d = 4'b0000;
        end
    end

    assign signal_o = sig_q;

endmodule

// File: rtl/multi_stepper_driver.sv
// -----------------------------------------------------------------------------
// multi_stepper_driver
// N-channel stepper-motor driver. Each channel runs a programmable move of
// K steps paced by an internal STEP_DIV divider; this level only slices the
// interface buses onto N_CH independent stepper_channel instances.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         multi_stepper_driver_if.slave (start/dir/steps/abort in,
//               busy/done/coil signal out)
// Parameters: N_CH, STEP_DIV (>=2), CNT_W, IDLE_RELEASE.
// Configuration macro: HALF_STEP_EN (half-step coil sequence when defined).
// -----------------------------------------------------------------------------
module multi_stepper_driver
    import stepper_drv_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int STEP_DIV     = 100000,
    parameter int CNT_W        = 16,
    parameter int IDLE_RELEASE = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    multi_stepper_driver_if.slave bus
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        stepper_channel #(
            .STEP_DIV     (STEP_DIV),
            .CNT_W        (CNT_W),
            .IDLE_RELEASE (IDLE_RELEASE)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (bus.start_i[c]),
            .dir_i    (bus.dir_i[c]),
            .steps_i  (bus.steps_i[c*CNT_W +: CNT_W]),
            .abort_i  (bus.abort_i[c]),
            .busy_o   (bus.busy_o[c]),
            .done_o   (bus.done_o[c]),
            .signal_o (bus.signal_o[c*4 +: 4])
        );
    end

endmodule

// File: tb/tb_multi_stepper_driver.sv
// -----------------------------------------------------------------------------
// tb_multi_stepper_driver
// Self-checking bench for multi_stepper_driver (N_CH=2, STEP_DIV=4, CNT_W=8,
// IDLE_RELEASE=1). The reference model works purely in time offsets from the
// accepting edge E0: a move ends at t_end = min(K*STEP_DIV, abort edge); the
// step count seen at offset t is floor(min(t, t_end)/STEP_DIV); busy is t<t_end,
// done is t==t_end, coils show pattern(position) for 1<=t<=t_end, else 0000.
// Honours HALF_STEP_EN for the expected coil table.
// -----------------------------------------------------------------------------
module tb_multi_stepper_driver;

    localparam int N_CH     = 2;
    localparam int STEP_DIV = 4;
    localparam int CNT_W    = 8;
`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_stepper_driver_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    multi_stepper_driver #(
        .N_CH         (N_CH),
        .STEP_DIV     (STEP_DIV),
        .CNT_W        (CNT_W),
        .IDLE_RELEASE (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Motor position per channel (unbounded integer, reduced mod NPH on use).
    int pos [N_CH];

    // Move descriptor filled in by each test before calling run_move.
    bit mv_en  [N_CH];
    int mv_k   [N_CH];
    bit mv_dir [N_CH];
    int mv_ab  [N_CH];   // 0 = no abort, else abort sampled at edge E0+mv_ab
    bit mv_rep;          // re-pulse start_i (with junk operands) during RUN

    function automatic logic [3:0] pattern(input int p);
        int i;
        i = ((p % NPH) + NPH) % NPH;
`ifdef HALF_STEP_EN
        case (i)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0100;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b1001;
        endcase
`else
        case (i)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            default: return 4'b1000;
        endcase
`endif
    endfunction

    task automatic clear_move();
        for (int c = 0; c < N_CH; c++) begin
            mv_en[c]  = 1'b0;
            mv_k[c]   = 0;
            mv_dir[c] = 1'b0;
            mv_ab[c]  = 0;
        end
        mv_rep = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (bus.busy_o !== '0) begin
            bad++;
            $display("FAIL %s busy_o got=%b want=0", name, bus.busy_o);
        end
        total++;
        if (bus.done_o !== '0) begin
            bad++;
            $display("FAIL %s done_o got=%b want=0", name, bus.done_o);
        end
        total++;
        if (bus.signal_o !== '0) begin
            bad++;
            $display("FAIL %s signal_o got=%h want=0", name, bus.signal_o);
        end
    endtask

    // Runs the described move from the next edge (E0) until every channel is
    // back in IDLE, checking all channels after every edge.
    task automatic run_move(input string name);
        int t_end [N_CH];
        int tmax;
        int st;
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_sig;
        tmax = 0;
        for (int c = 0; c < N_CH; c++) begin
            t_end[c] = -1;
            if (mv_en[c]) begin
                t_end[c] = mv_k[c] * STEP_DIV;
                if (mv_ab[c] > 0 && mv_ab[c] < t_end[c]) t_end[c] = mv_ab[c];
                if (t_end[c] > tmax) tmax = t_end[c];
                bus.start_i[c] = 1'b1;
                bus.dir_i[c]   = mv_dir[c];
                bus.steps_i[c*CNT_W +: CNT_W] = mv_k[c][CNT_W-1:0];
            end
        end
        for (int t = 0; t <= tmax + 1; t++) begin
            if (t == 0) begin
                @(posedge clk);
                #1;
                bus.start_i = '0;
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (mv_en[c] && mv_ab[c] == t) bus.abort_i[c] = 1'b1;
                    if (mv_en[c] && mv_rep && t <= t_end[c] && (t % 3) == 1) begin
                        bus.start_i[c] = 1'b1;
                        bus.dir_i[c]   = ~mv_dir[c];
                        bus.steps_i[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 200));
                    end
                end
                @(posedge clk);
                #1;
                bus.abort_i = '0;
                bus.start_i = '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (mv_en[c]) begin
                    st     = ((t < t_end[c]) ? t : t_end[c]) / STEP_DIV;
                    e_busy = (t < t_end[c]);
                    e_done = (t == t_end[c]);
                    e_sig  = (t >= 1 && t <= t_end[c])
                             ? pattern(pos[c] + (mv_dir[c] ? st : -st)) : 4'b0000;
                end else begin
                    e_busy = 1'b0;
                    e_done = 1'b0;
                    e_sig  = 4'b0000;
                end
                total++;
                if (bus.busy_o[c] !== e_busy) begin
                    bad++;
                    $display("FAIL %s t=%0d ch%0d busy got=%b want=%b",
                             name, t, c, bus.busy_o[c], e_busy);
                end
                total++;
                if (bus.done_o[c] !== e_done) begin
                    bad++;
                    $display("FAIL %s t=%0d ch%0d done got=%b want=%b",
                             name, t, c, bus.done_o[c], e_done);
                end
                total++;
                if (bus.signal_o[c*4 +: 4] !== e_sig) begin
                    bad++;
                    $display("FAIL %s t=%0d ch%0d signal got=%b want=%b",
                             name, t, c, bus.signal_o[c*4 +: 4], e_sig);
                end
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (mv_en[c]) begin
                st = t_end[c] / STEP_DIV;
                pos[c] = pos[c] + (mv_dir[c] ? st : -st);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_initial");
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) pos[c] = 0;
        @(posedge clk);
        #1;
        check_all_zero("reset_released_idle");
    endtask

    task automatic test_forward();
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 5; mv_dir[0] = 1'b1;
        run_move("fwd5_ch0");
    endtask

    task automatic test_reverse();
        clear_move();
        mv_en[1] = 1'b1; mv_k[1] = 3; mv_dir[1] = 1'b0;
        run_move("rev3_ch1");
    endtask

    task automatic test_zero_steps();
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 0; mv_dir[0] = 1'b1;
        run_move("zero_ch0");
    endtask

    task automatic test_abort();
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 10; mv_dir[0] = 1'b1; mv_ab[0] = 6;
        run_move("abort_e6");
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 10; mv_dir[0] = 1'b1; mv_ab[0] = 8;
        run_move("abort_e8_coincident");
    endtask

    task automatic test_simultaneous();
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 2; mv_dir[0] = 1'b1;
        mv_en[1] = 1'b1; mv_k[1] = 4; mv_dir[1] = 1'b0;
        mv_rep   = 1'b1;
        run_move("both_start_repulse");
    endtask

    task automatic test_reset_mid_move();
        bus.start_i[0] = 1'b1;
        bus.dir_i[0]   = 1'b1;
        bus.steps_i[0 +: CNT_W] = CNT_W'(5);
        @(posedge clk);
        #1;
        bus.start_i = '0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_move_async");
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_move_held");
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) pos[c] = 0;
        @(posedge clk);
        #1;
        check_all_zero("reset_mid_move_no_done");
        clear_move();
        mv_en[0] = 1'b1; mv_k[0] = 1; mv_dir[0] = 1'b1;
        run_move("restart_from_phase0");
    endtask

    task automatic test_max_count();
        clear_move();
        mv_en[1] = 1'b1; mv_k[1] = (1 << CNT_W) - 1; mv_dir[1] = 1'b1;
        run_move("max_steps_ch1");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            clear_move();
            for (int c = 0; c < N_CH; c++) begin
                mv_en[c]  = 1'($urandom_range(0, 1));
                mv_k[c]   = $urandom_range(0, 6);
                mv_dir[c] = 1'($urandom_range(0, 1));
                if (mv_k[c] > 0 && $urandom_range(0, 2) == 0)
                    mv_ab[c] = $urandom_range(1, mv_k[c] * STEP_DIV);
            end
            mv_rep = 1'($urandom_range(0, 1));
            run_move($sformatf("random_%0d", it));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.start_i = '0;
        bus.dir_i   = '0;
        bus.steps_i = '0;
        bus.abort_i = '0;
        test_reset();
        test_forward();
        test_reverse();
        test_zero_steps();
        test_abort();
        test_simultaneous();
        test_reset_mid_move();
        test_max_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
